// File: rtl/switch_debounce_pkg.sv
// rtl/switch_debounce_pkg.sv - FSM state encoding and parameter defaults for switch_debounce
package switch_debounce_pkg;

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'd0,
      WAIT_HIGH   = 2'd1,
      STABLE_HIGH = 2'd2,
      WAIT_LOW    = 2'd3
   } state_t;

   localparam int DEFAULT_SYNC_STAGES     = 2;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-flop synchronizer for an asynchronous level, reset to 0
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   if (STAGES < 2) begin : g_bad_stages
      $error("sync_chain: STAGES must be at least 2");
   end

   logic [STAGES-1:0] flops;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flops <= '0;
      end else begin
         flops <= {flops[STAGES-2:0], d};
      end
   end

   assign q = flops[STAGES-1];

endmodule

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - synchronize and debounce a mechanical switch, with edge pulses
module switch_debounce
   import switch_debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = switch_debounce_pkg::DEFAULT_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = switch_debounce_pkg::DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic switch,
   output logic switch_db,
   output logic rise,
   output logic fall,
   output logic bouncing
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("switch_debounce: SYNC_STAGES must be at least 2");
   end
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("switch_debounce: DEBOUNCE_CYCLES must be at least 2");
   end

   localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s;
   state_t           state;
   logic [CNT_W-1:0] cnt;

   sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (switch),
      .q     (s)
   );

   // The cycle that enters WAIT counts as the first stable sample, so the
   // counter reaching CNT_LAST means DEBOUNCE_CYCLES+1 agreeing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= STABLE_LOW;
         cnt       <= '0;
         switch_db <= 1'b0;
         rise      <= 1'b0;
         fall      <= 1'b0;
         bouncing  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            STABLE_LOW: begin
               if (s) begin
                  state    <= WAIT_HIGH;
                  cnt      <= '0;
                  bouncing <= 1'b1;
               end
            end
            WAIT_HIGH: begin
               if (!s) begin
                  state    <= STABLE_LOW;
                  cnt      <= '0;
                  bouncing <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state     <= STABLE_HIGH;
                  cnt       <= '0;
                  switch_db <= 1'b1;
                  rise      <= 1'b1;
                  bouncing  <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            STABLE_HIGH: begin
               if (!s) begin
                  state    <= WAIT_LOW;
                  cnt      <= '0;
                  bouncing <= 1'b1;
               end
            end
            WAIT_LOW: begin
               if (s) begin
                  state    <= STABLE_HIGH;
                  cnt      <= '0;
                  bouncing <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state     <= STABLE_LOW;
                  cnt       <= '0;
                  switch_db <= 1'b0;
                  fall      <= 1'b1;
                  bouncing  <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state     <= STABLE_LOW;
               cnt       <= '0;
               switch_db <= 1'b0;
               bouncing  <= 1'b0;
            end
         endcase
      end
   end

endmodule
